// File: rtl/log_controller_if.sv
// Handshake and memory-port bundle for log_controller.
// slave: the controller; master: writer, reader and memory side.
interface log_controller_if #(
    parameter int AW = 9,
    parameter int DW = 17
);
    logic          log_valid;
    logic [DW-1:0] log_data;
    logic          log_ready;
    logic          rd_req;
    logic [AW-1:0] rd_offset;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic          clr_req;
    logic          busy;
    logic [AW:0]   count;
    logic          wrapped;
    logic [AW-1:0] mem_idx;
    logic          mem_wr;
    logic          mem_enable;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  log_valid, log_data, rd_req, rd_offset,
        input  clr_req, mem_rdata,
        output log_ready, rd_ack, rd_valid, rd_data, rd_err,
        output busy, count, wrapped,
        output mem_idx, mem_wr, mem_enable, mem_wdata
    );

    modport master (
        output log_valid, log_data, rd_req, rd_offset,
        output clr_req, mem_rdata,
        input  log_ready, rd_ack, rd_valid, rd_data, rd_err,
        input  busy, count, wrapped,
        input  mem_idx, mem_wr, mem_enable, mem_wdata
    );
endinterface

// File: rtl/log_controller.sv
// Circular event log sequencer: arbitrates writer/reader on one memory port.
// Ports: clk, reset (async, active-high), bus (log_controller_if.slave).
module log_controller #(
    parameter int AW = 9,
    parameter int DW = 17
) (
    input logic              clk,
    input logic              reset,
    log_controller_if.slave  bus
);
    localparam int         DEPTH = 1 << AW;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        CLEAR
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] ridx;
    logic [AW-1:0] clr_ptr;
    logic [AW:0]   cnt;
    // 1 when the writer won the most recent grant
    logic          last_log;
    logic [DW-1:0] wdata;
    logic          err_pend;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;
    logic          rd_err_q;
    logic          wrapped_q;
    logic          grant_log;
    logic          grant_rd;

    // Clear beats both requesters; a tie goes to the side
    // that did not win last time.
    always_comb begin
        grant_log = 1'b0;
        grant_rd  = 1'b0;
        state_nx  = state;
        unique case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nx = CLEAR;
                end else if (bus.log_valid &&
                             (!bus.rd_req || !last_log)) begin
                    grant_log = 1'b1;
                    state_nx  = WRITE;
                end else if (bus.rd_req) begin
                    grant_rd = 1'b1;
                    state_nx = READ;
                end
            end
            WRITE:   state_nx = IDLE;
            READ:    state_nx = IDLE;
            CLEAR: begin
                if (clr_ptr == '1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_enable = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_idx    = '0;
        bus.mem_wdata  = '0;
        case (state)
            WRITE: begin
                bus.mem_enable = 1'b1;
                bus.mem_wr     = 1'b1;
                bus.mem_idx    = wr_ptr;
                bus.mem_wdata  = wdata;
            end
            READ: begin
                // out-of-range reads never touch the memory
                bus.mem_enable = !err_pend;
                bus.mem_idx    = err_pend ? '0 : ridx;
            end
            CLEAR: begin
                bus.mem_enable = 1'b1;
                bus.mem_wr     = 1'b1;
                bus.mem_idx    = clr_ptr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            ridx       <= '0;
            clr_ptr    <= '0;
            cnt        <= '0;
            last_log   <= 1'b0;
            wdata      <= '0;
            err_pend   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            rd_valid_q <= 1'b0;
            if (grant_log) begin
                wdata    <= bus.log_data;
                last_log <= 1'b1;
            end
            if (grant_rd) begin
                // offset 0 is the slot just behind the write pointer
                ridx     <= wr_ptr - AW'(1) - bus.rd_offset;
                err_pend <= {1'b0, bus.rd_offset} >= cnt;
                last_log <= 1'b0;
            end
            case (state)
                WRITE: begin
                    wr_ptr <= wr_ptr + AW'(1);
                    if (cnt == FULL) wrapped_q <= 1'b1;
                    else cnt <= cnt + (AW+1)'(1);
                end
                READ: begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= err_pend ? '0 : bus.mem_rdata;
                    rd_err_q   <= err_pend;
                end
                CLEAR: begin
                    clr_ptr <= clr_ptr + AW'(1);
                    if (clr_ptr == '1) begin
                        wr_ptr    <= '0;
                        cnt       <= '0;
                        wrapped_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.log_ready = grant_log;
    assign bus.rd_ack    = grant_rd;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_err    = rd_err_q;
    assign bus.busy      = (state != IDLE);
    assign bus.count     = cnt;
    assign bus.wrapped   = wrapped_q;
endmodule

// File: tb/tb_log_controller.sv
// Self-checking bench for log_controller: queue-based log model,
// directed scenarios and randomized traffic.
module tb_log_controller;
    localparam int AW    = 9;
    localparam int DW    = 17;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    log_controller_if #(.AW(AW), .DW(DW)) mif ();

    log_controller #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk)
        if (mif.mem_enable && mif.mem_wr)
            mem[mif.mem_idx] <= mif.mem_wdata;
    assign mif.mem_rdata = mem[mif.mem_idx];

    int total = 0;
    int bad = 0;

    task automatic check(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // reference model: the log is a queue, oldest first
    logic [DW-1:0] q[$];
    bit            m_wrapped;
    int            wptr;
    bit            last_rd;
    longint        cyc = 0;
    longint        busy_until;
    longint        wr_cyc, rd_cyc, rd_due;
    longint        clr_start, clr_end;
    logic [DW-1:0] wpend;
    logic [DW-1:0] rdat;
    bit            rerr;
    int            ridx;

    // observations handed to the stimulus
    bit            fired_log, fired_rd, got_rv;
    logic [DW-1:0] rv_data;
    bit            rv_err;
    longint        ack_cyc, rv_cyc;
    bit            gq[$];

    task automatic model_init();
        q.delete();
        m_wrapped  = 0;
        wptr       = 0;
        last_rd    = 1;
        busy_until = -1;
        wr_cyc     = -10;
        rd_cyc     = -10;
        rd_due     = -10;
        clr_start  = -10;
        clr_end    = -10;
    endtask

    task automatic monitor();
        bit idle, elr, era, inclr;
        int off;
        fired_log = 0;
        fired_rd  = 0;
        got_rv    = 0;
        if (reset) begin
            model_init();
            return;
        end
        idle  = cyc > busy_until;
        elr   = idle && !mif.clr_req && mif.log_valid
                && (!mif.rd_req || last_rd);
        era   = idle && !mif.clr_req && mif.rd_req && !elr;
        inclr = cyc > clr_start && cyc <= clr_end;

        check("log_ready", mif.log_ready, elr);
        check("rd_ack", mif.rd_ack, era);
        check("busy", mif.busy, !idle);
        check("count", mif.count, q.size());
        check("wrapped", mif.wrapped, m_wrapped);
        check("rd_valid", mif.rd_valid, cyc == rd_due);
        if (cyc == rd_due) begin
            check("rd_data", mif.rd_data, rdat);
            check("rd_err", mif.rd_err, rerr);
        end
        if (cyc == wr_cyc) begin
            check("wr_en", mif.mem_enable, 1);
            check("wr_we", mif.mem_wr, 1);
            check("wr_idx", mif.mem_idx, wptr);
            check("wr_data", mif.mem_wdata, wpend);
        end else if (cyc == rd_cyc) begin
            check("rd_en", mif.mem_enable, !rerr);
            if (!rerr) begin
                check("rd_we", mif.mem_wr, 0);
                check("rd_idx", mif.mem_idx, ridx);
            end
        end else if (inclr) begin
            check("clr_en", mif.mem_enable, 1);
            check("clr_we", mif.mem_wr, 1);
            check("clr_idx", mif.mem_idx, cyc - clr_start - 1);
            check("clr_data", mif.mem_wdata, 0);
        end else begin
            check("idle_en", mif.mem_enable, 0);
        end

        fired_log = mif.log_valid && mif.log_ready;
        fired_rd  = mif.rd_req && mif.rd_ack;
        if (fired_log) gq.push_back(1'b1);
        if (fired_rd) begin
            gq.push_back(1'b0);
            ack_cyc = cyc;
        end
        if (mif.rd_valid) begin
            got_rv  = 1;
            rv_data = mif.rd_data;
            rv_err  = mif.rd_err;
            rv_cyc  = cyc;
        end

        if (cyc == wr_cyc) begin
            if (q.size() == DEPTH) begin
                void'(q.pop_front());
                m_wrapped = 1;
            end
            q.push_back(wpend);
            wptr = (wptr + 1) % DEPTH;
        end
        if (cyc == clr_end) begin
            q.delete();
            m_wrapped = 0;
            wptr = 0;
        end
        if (elr) begin
            wpend      = mif.log_data;
            wr_cyc     = cyc + 1;
            busy_until = cyc + 1;
            last_rd    = 0;
        end
        if (era) begin
            off  = int'(mif.rd_offset);
            rerr = off >= q.size();
            rdat = rerr ? '0 : q[q.size() - 1 - off];
            ridx = (wptr - 1 - off + 2 * DEPTH) % DEPTH;
            rd_cyc     = cyc + 1;
            rd_due     = cyc + 2;
            busy_until = cyc + 1;
            last_rd    = 1;
        end
        if (idle && mif.clr_req) begin
            clr_start  = cyc;
            clr_end    = cyc + DEPTH;
            busy_until = cyc + DEPTH;
        end
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic append(logic [DW-1:0] d);
        bit ok = 0;
        mif.log_valid = 1;
        mif.log_data  = d;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (fired_log) begin
                ok = 1;
                break;
            end
        end
        mif.log_valid = 0;
        if (!ok) check("append_timeout", 0, 1);
    endtask

    task automatic do_read(input logic [AW-1:0] off,
                           output logic [DW-1:0] d, output bit e,
                           output bit en, output int lat);
        bit ok = 0;
        longint a = 0;
        d = '0;
        e = 0;
        en = 0;
        lat = -1;
        mif.rd_req    = 1;
        mif.rd_offset = off;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (fired_rd) begin
                ok = 1;
                a = ack_cyc;
                break;
            end
        end
        mif.rd_req = 0;
        en = mif.mem_enable;
        if (!ok) begin
            check("read_ack_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (got_rv) begin
                d = rv_data;
                e = rv_err;
                lat = int'(rv_cyc - a);
                return;
            end
        end
        check("read_valid_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (3) cycle();
        reset = 0;
    endtask

    initial begin
        logic [DW-1:0] d;
        bit e, en;
        int lat, n, nl, nr, m;

        mif.log_valid = 0;
        mif.log_data  = '0;
        mif.rd_req    = 0;
        mif.rd_offset = '0;
        mif.clr_req   = 0;
        model_init();
        do_reset();

        check("rst_count", mif.count, 0);
        check("rst_wrapped", mif.wrapped, 0);
        check("rst_busy", mif.busy, 0);
        check("rst_rd_valid", mif.rd_valid, 0);
        check("rst_rd_data", mif.rd_data, 0);
        check("rst_rd_err", mif.rd_err, 0);
        check("rst_mem_en", mif.mem_enable, 0);
        check("rst_mem_wr", mif.mem_wr, 0);
        check("rst_mem_idx", mif.mem_idx, 0);
        cycle();

        for (int i = 0; i < 3; i++) begin
            append(DW'((i + 1) * 'h11));
            check("t1_idx", mif.mem_idx, i);
            check("t1_wdata", mif.mem_wdata, (i + 1) * 'h11);
        end
        cycle();
        check("t1_count", mif.count, 3);
        check("t1_model_count", q.size(), 3);
        check("t1_model_wptr", wptr, 3);

        do_read(0, d, e, en, lat);
        check("t2_off0_data", d, 'h33);
        check("t2_off0_err", e, 0);
        check("t2_off0_lat", lat, 2);
        do_read(2, d, e, en, lat);
        check("t2_off2_data", d, 'h11);
        check("t2_off2_err", e, 0);
        do_read(3, d, e, en, lat);
        check("t2_off3_data", d, 0);
        check("t2_off3_err", e, 1);
        check("t2_off3_en", en, 0);
        check("t2_off3_lat", lat, 2);

        gq.delete();
        mif.log_valid = 1;
        mif.log_data  = DW'($urandom);
        mif.rd_req    = 1;
        mif.rd_offset = '0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (fired_log) mif.log_data = DW'($urandom);
        end
        mif.log_valid = 0;
        mif.rd_req = 0;
        repeat (4) cycle();
        nl = 0;
        nr = 0;
        foreach (gq[i]) if (gq[i]) nl++; else nr++;
        check("t3_ngrants", gq.size() >= 4, 1);
        if (gq.size() >= 4) begin
            check("t3_g0", gq[0], 1);
            check("t3_g1", gq[1], 0);
            check("t3_g2", gq[2], 1);
            check("t3_g3", gq[3], 0);
        end
        check("t3_no_starve", nl >= 4 && nr >= 4, 1);

        do_reset();
        for (int v = 0; v < 515; v++) begin
            append(DW'(v));
            if (v == 511) begin
                cycle();
                check("t4_count512", mif.count, 512);
                check("t4_wrap_before", mif.wrapped, 0);
            end
            if (v == 512) begin
                cycle();
                check("t4_wrap_after", mif.wrapped, 1);
            end
        end
        cycle();
        check("t4_count_sat", mif.count, 512);
        check("t4_model_count", q.size(), 512);
        do_read(0, d, e, en, lat);
        check("t4_off0", d, 514);
        check("t4_off0_err", e, 0);
        do_read(511, d, e, en, lat);
        check("t4_off511", d, 3);
        check("t4_off511_err", e, 0);

        mif.clr_req = 1;
        cycle();
        mif.clr_req = 0;
        n = 0;
        while (mif.busy && n < 600) begin
            n++;
            cycle();
        end
        check("t5_busy_cycles", n, 512);
        check("t5_count", mif.count, 0);
        check("t5_wrapped", mif.wrapped, 0);
        do_read(0, d, e, en, lat);
        check("t5_read_err", e, 1);
        check("t5_read_data", d, 0);

        append(DW'('h0ABCD));
        cycle();
        mif.clr_req = 1;
        cycle();
        mif.clr_req = 0;
        n = 0;
        while (mif.mem_idx != AW'(100) && n < 600) begin
            n++;
            cycle();
        end
        check("t6_reach_100", mif.mem_idx == AW'(100) && mif.busy, 1);
        #2 reset = 1;
        #1;
        check("t6_clr_rst_en", mif.mem_enable, 0);
        check("t6_clr_rst_wr", mif.mem_wr, 0);
        check("t6_clr_rst_idx", mif.mem_idx, 0);
        check("t6_clr_rst_wdata", mif.mem_wdata, 0);
        check("t6_clr_rst_busy", mif.busy, 0);
        check("t6_clr_rst_count", mif.count, 0);
        repeat (2) cycle();
        reset = 0;
        append(DW'('h1ABCD));
        check("t6_first_idx", mif.mem_idx, 0);
        cycle();

        mif.rd_req = 1;
        mif.rd_offset = '0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!fired_rd && n < 50);
        mif.rd_req = 0;
        check("t6_rd_acked", fired_rd, 1);
        #2 reset = 1;
        #1;
        check("t6_rd_rst_busy", mif.busy, 0);
        check("t6_rd_rst_en", mif.mem_enable, 0);
        check("t6_rd_rst_valid", mif.rd_valid, 0);
        repeat (2) cycle();
        reset = 0;
        n = 0;
        repeat (5) begin
            cycle();
            if (got_rv) n++;
        end
        check("t6_no_rd_valid", n, 0);

        for (int i = 0; i < 4000; i++) begin
            if (fired_log) mif.log_valid = 0;
            if (fired_rd) mif.rd_req = 0;
            mif.clr_req = 0;
            if (!mif.log_valid && $urandom_range(99) < 40) begin
                mif.log_valid = 1;
                mif.log_data  = DW'($urandom);
            end
            if (!mif.rd_req && $urandom_range(99) < 40) begin
                mif.rd_req = 1;
                if ($urandom_range(3) == 0) begin
                    mif.rd_offset = AW'($urandom);
                end else begin
                    m = q.size() + 2;
                    if (m > DEPTH - 1) m = DEPTH - 1;
                    mif.rd_offset = AW'($urandom_range(m, 0));
                end
            end
            if ($urandom_range(1499) == 0) mif.clr_req = 1;
            cycle();
        end
        mif.log_valid = 0;
        mif.rd_req = 0;
        mif.clr_req = 0;
        n = 0;
        while (mif.busy && n < 600) begin
            n++;
            cycle();
        end
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
